// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared widths, slot encoding and result record for the FPCVT arbiter
package fpcvt_pkg;

  localparam int FP_DW = 12;
  localparam int FP_EW = 3;
  localparam int FP_FW = 4;

  typedef enum logic [1:0] {
    SLOT_EMPTY    = 2'b00,
    SLOT_INFLIGHT = 2'b01,
    SLOT_FULL     = 2'b10
  } slot_e;

  typedef struct packed {
    logic             s;
    logic [FP_EW-1:0] e;
    logic [FP_FW-1:0] f;
  } res_t;

endpackage

// File: rtl/fpcvt.sv
// rtl/fpcvt.sv - combinational 12-bit two's complement to (S, E, F) converter, half-up rounding
module fpcvt
  import fpcvt_pkg::*;
(
  input  logic [FP_DW-1:0] d_i,
  output logic             s_o,
  output logic [FP_EW-1:0] e_o,
  output logic [FP_FW-1:0] f_o
);

  logic [FP_DW-1:0] mag;
  logic [3:0]       pos;
  logic [FP_EW-1:0] e0;
  logic [FP_FW-1:0] f0;
  logic             rnd;
  logic [FP_FW:0]   fr;

  always_comb begin
    mag = d_i[FP_DW-1] ? (~d_i + 12'd1) : d_i;
    pos = 4'd0;
    for (int i = 0; i < FP_DW; i++) begin
      if (mag[i]) pos = 4'(i);
    end
    // Exponent is the shift that leaves the leading one at the top of the 4-bit window.
    e0  = (pos >= 4'd3) ? 3'(pos - 4'd3) : 3'd0;
    f0  = 4'(mag >> e0);
    rnd = (e0 != 3'd0) ? mag[{1'b0, e0} - 4'd1] : 1'b0;
    fr  = {1'b0, f0} + {4'd0, rnd};

    s_o = d_i[FP_DW-1];
    e_o = e0;
    f_o = fr[FP_FW-1:0];
    if (fr[FP_FW]) begin
      if (e0 == 3'd7) begin
        f_o = 4'b1111;
      end else begin
        e_o = e0 + 3'd1;
        f_o = 4'b1000;
      end
    end
    // Only -2048 reaches bit 11 of the magnitude; it is beyond the representable range.
    if (mag[FP_DW-1]) begin
      e_o = 3'd7;
      f_o = 4'b1111;
    end
  end

endmodule

// File: rtl/fpcvt_arb.sv
// rtl/fpcvt_arb.sv - round-robin sharing of one FPCVT between two valid/ready requesters
module fpcvt_arb
  import fpcvt_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [FP_DW-1:0] req_data0,
  input  logic [FP_DW-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic             resp_s0,
  output logic [FP_EW-1:0] resp_e0,
  output logic [FP_FW-1:0] resp_f0,
  output logic             resp_s1,
  output logic [FP_EW-1:0] resp_e1,
  output logic [FP_FW-1:0] resp_f1,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  slot_e            slot_q [2];
  slot_e            slot_d [2];
  res_t             res_q  [2];
  res_t             res_d  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic [FP_DW-1:0] d_q, d_d;
  logic             own_q, own_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;

  logic [1:0]       elig;
  logic             gnt_any;
  logic             gnt_idx;
  res_t             cvt;
  logic             cvt_s;
  logic [FP_EW-1:0] cvt_e;
  logic [FP_FW-1:0] cvt_f;

  fpcvt u_fpcvt (
    .d_i (d_q),
    .s_o (cvt_s),
    .e_o (cvt_e),
    .f_o (cvt_f)
  );

  always_comb begin
    cvt = '{s: cvt_s, e: cvt_e, f: cvt_f};

    for (int i = 0; i < 2; i++) begin
      elig[i]       = ~rst & req_valid[i] &
                      ((slot_q[i] == SLOT_EMPTY) | ((slot_q[i] == SLOT_FULL) & resp_ready[i]));
      resp_valid[i] = (slot_q[i] == SLOT_FULL);
    end
    gnt_any   = |elig;
    gnt_idx   = (elig == 2'b11) ? ~last_q : elig[1];
    req_ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    d_d    = d_q;
    own_d  = own_q;
    last_d = last_q;
    busy_d = gnt_any;
    if (gnt_any) begin
      own_d  = gnt_idx;
      last_d = gnt_idx;
      d_d    = gnt_idx ? req_data1 : req_data0;
    end

    // Completion, drain and refill may all touch a slot in one cycle; refill wins last.
    for (int i = 0; i < 2; i++) begin
      slot_d[i] = slot_q[i];
      res_d[i]  = res_q[i];
      cnt_d[i]  = cnt_q[i];
      if (busy_q && (own_q == 1'(i))) begin
        slot_d[i] = SLOT_FULL;
        res_d[i]  = cvt;
      end
      if ((slot_q[i] == SLOT_FULL) && resp_ready[i]) begin
        slot_d[i] = SLOT_EMPTY;
        cnt_d[i]  = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (gnt_any && (gnt_idx == 1'(i))) begin
        slot_d[i] = SLOT_INFLIGHT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= SLOT_EMPTY;
        res_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
      d_q    <= '0;
      own_q  <= 1'b0;
      busy_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
        res_q[i]  <= res_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      d_q    <= d_d;
      own_q  <= own_d;
      busy_q <= busy_d;
      last_q <= last_d;
    end
  end

  assign resp_s0   = res_q[0].s;
  assign resp_e0   = res_q[0].e;
  assign resp_f0   = res_q[0].f;
  assign resp_s1   = res_q[1].s;
  assign resp_e1   = res_q[1].e;
  assign resp_f1   = res_q[1].f;
  assign done_cnt0 = cnt_q[0];
  assign done_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_fpcvt_arb.sv
// tb/tb_fpcvt_arb.sv - scoreboard bench for the two-port FPCVT arbiter
module tb_fpcvt_arb;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [11:0]      req_data0;
  logic [11:0]      req_data1;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic             resp_s0;
  logic [2:0]       resp_e0;
  logic [3:0]       resp_f0;
  logic             resp_s1;
  logic [2:0]       resp_e1;
  logic [3:0]       resp_f1;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;

  int total;
  int bad;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  fpcvt_arb #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_s0    (resp_s0),
    .resp_e0    (resp_e0),
    .resp_f0    (resp_f0),
    .resp_s1    (resp_s1),
    .resp_e1    (resp_e1),
    .resp_f1    (resp_f1),
    .done_cnt0  (done_cnt0),
    .done_cnt1  (done_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift until the magnitude fits 4 bits, then round half-up with the dropped bits.
  function automatic logic [7:0] model(input logic [11:0] d);
    int mag;
    int e;
    int f;
    logic s;
    s   = d[11];
    mag = s ? (4096 - int'(d)) : int'(d);
    e   = 0;
    while ((mag >> e) > 15) e++;
    f = (e > 0) ? ((mag + (1 << (e - 1))) >> e) : mag;
    if (f == 16) begin
      f = 8;
      e++;
    end
    if (e > 7) begin
      e = 7;
      f = 15;
    end
    return {s, 3'(e), 4'(f)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid[0] && req_ready[0]) q0.push_back(model(req_data0));
      if (req_valid[1] && req_ready[1]) q1.push_back(model(req_data1));
      if (resp_valid[0] && resp_ready[0]) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL sb_resp0: got unexpected response %0h want none", {resp_s0, resp_e0, resp_f0});
        end else if ({resp_s0, resp_e0, resp_f0} !== q0[0]) begin
          bad++;
          $display("FAIL sb_resp0: got %0h want %0h", {resp_s0, resp_e0, resp_f0}, q0[0]);
        end
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (resp_valid[1] && resp_ready[1]) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL sb_resp1: got unexpected response %0h want none", {resp_s1, resp_e1, resp_f1});
        end else if ({resp_s1, resp_e1, resp_f1} !== q1[0]) begin
          bad++;
          $display("FAIL sb_resp1: got %0h want %0h", {resp_s1, resp_e1, resp_f1}, q1[0]);
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({req_ready, resp_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hs: got ready=%b valid=%b want 00/00", req_ready, resp_valid);
    end
    total++;
    if ({resp_s0, resp_e0, resp_f0, resp_s1, resp_e1, resp_f1, done_cnt0, done_cnt1} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %0h/%0h cnt %0d/%0d want zeros",
               {resp_s0, resp_e0, resp_f0}, {resp_s1, resp_e1, resp_f1}, done_cnt0, done_cnt1);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    req_valid = 2'b01;
    req_data0 = 12'd422;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL basic_ready: got %b want 01", req_ready);
    end
    cyc();
    req_valid = 2'b00;
    #1;
    total++;
    if (resp_valid !== 2'b00) begin
      bad++;
      $display("FAIL basic_latency: got %b want 00", resp_valid);
    end
    cyc();
    #1;
    total++;
    if ({resp_valid, resp_s0, resp_e0, resp_f0} !== {2'b01, 1'b0, 3'd5, 4'b1101}) begin
      bad++;
      $display("FAIL basic_result: got v=%b %0h want v=01 %0h", resp_valid, {resp_s0, resp_e0, resp_f0}, 8'h5D);
    end
    resp_ready = 2'b01;
    cyc();
    #1;
    total++;
    if ({done_cnt0, resp_valid} !== {8'd1, 2'b00}) begin
      bad++;
      $display("FAIL basic_count: got cnt=%0d v=%b want 1/00", done_cnt0, resp_valid);
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_alternate();
    apply_reset();
    resp_ready = 2'b11;
    req_valid  = 2'b11;
    req_data0  = 12'd56;
    req_data1  = 12'h800;
    for (int i = 0; i < 12; i++) begin
      #1;
      total++;
      if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL alt_grant%0d: got %b want %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i == 3) begin
        total++;
        if ({resp_valid, resp_s1, resp_e1, resp_f1} !== {2'b10, 1'b1, 3'd7, 4'b1111}) begin
          bad++;
          $display("FAIL alt_res1: got v=%b %0h want v=10 ff", resp_valid, {resp_s1, resp_e1, resp_f1});
        end
      end
      if (i == 4) begin
        total++;
        if ({resp_valid, resp_s0, resp_e0, resp_f0} !== {2'b01, 1'b0, 3'd2, 4'b1110}) begin
          bad++;
          $display("FAIL alt_res0: got v=%b %0h want v=01 2e", resp_valid, {resp_s0, resp_e0, resp_f0});
        end
      end
      cyc();
    end
    req_valid = 2'b00;
    repeat (4) cyc();
    #1;
    total++;
    if ({done_cnt0, done_cnt1} !== {8'd6, 8'd6}) begin
      bad++;
      $display("FAIL alt_counts: got %0d/%0d want 6/6", done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    apply_reset();
    resp_ready = 2'b01;
    req_valid  = 2'b10;
    req_data1  = 12'hFFF;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL bp_first: got %b want 10", req_ready);
    end
    cyc();
    req_valid = 2'b11;
    req_data0 = 12'($urandom_range(0, 4095));
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL bp_second: got %b want 01", req_ready);
    end
    cyc();
    for (int i = 0; i < 10; i++) begin
      req_data0 = 12'($urandom_range(0, 4095));
      req_data1 = 12'($urandom_range(0, 4095));
      #1;
      if (req_ready[0]) acc++;
      total++;
      if ({req_ready[1], resp_valid[1], resp_s1, resp_e1, resp_f1} !== {1'b0, 1'b1, 1'b1, 3'd0, 4'b0001}) begin
        bad++;
        $display("FAIL bp_hold%0d: got rdy1=%b v1=%b %0h want 0/1 81",
                 i, req_ready[1], resp_valid[1], {resp_s1, resp_e1, resp_f1});
      end
      cyc();
    end
    total++;
    if (acc !== 5) begin
      bad++;
      $display("FAIL bp_rate0: got %0d accepts want 5", acc);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    repeat (3) cyc();
    #1;
    total++;
    if ({done_cnt0, done_cnt1} !== {8'd6, 8'd1}) begin
      bad++;
      $display("FAIL bp_counts: got %0d/%0d want 6/1", done_cnt0, done_cnt1);
    end
  endtask

  task automatic test_corners();
    logic [11:0] din [6];
    logic [7:0]  dexp [6];
    din  = '{12'h000, 12'hFFF, 12'd2047, 12'h800, 12'd31, 12'hFE8};
    dexp = '{8'h00, 8'h81, 8'h7F, 8'hFF, 8'h28, 8'h9C};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b01;
      req_data0 = din[i];
      cyc();
      req_valid = 2'b00;
      cyc();
      #1;
      total++;
      if ({resp_valid[0], resp_s0, resp_e0, resp_f0} !== {1'b1, dexp[i]}) begin
        bad++;
        $display("FAIL corner_%0h: got v=%b %0h want v=1 %0h", din[i], resp_valid[0],
                 {resp_s0, resp_e0, resp_f0}, dexp[i]);
      end
      resp_ready = 2'b01;
      cyc();
      resp_ready = 2'b00;
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_valid = 2'b10;
    req_data1 = 12'd422;
    cyc();
    req_valid = 2'b00;
    cyc();
    req_valid = 2'b01;
    req_data0 = 12'd100;
    #1;
    total++;
    if ({resp_valid, req_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL mid_setup: got v=%b rdy=%b want 10/01", resp_valid, req_ready);
    end
    cyc();
    req_valid = 2'b11;
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    total++;
    if ({req_ready, resp_valid, resp_s0, resp_e0, resp_f0, resp_s1, resp_e1, resp_f1,
         done_cnt0, done_cnt1} !== '0) begin
      bad++;
      $display("FAIL mid_zero: got rdy=%b v=%b %0h/%0h want all zero", req_ready, resp_valid,
               {resp_s0, resp_e0, resp_f0}, {resp_s1, resp_e1, resp_f1});
    end
    req_valid = 2'b00;
    @(posedge clk);
    #2;
    rst        = 1'b0;
    resp_ready = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (resp_valid !== 2'b00) begin
        bad++;
        $display("FAIL mid_stale%0d: got %b want 00", i, resp_valid);
      end
      cyc();
    end
    resp_ready = 2'b00;
  endtask

  task automatic test_wrap();
    apply_reset();
    resp_ready = 2'b01;
    req_valid  = 2'b01;
    repeat (511) begin
      req_data0 = 12'($urandom_range(0, 4095));
      cyc();
    end
    #1;
    total++;
    if (done_cnt0 !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_pre: got %0d want 255", done_cnt0);
    end
    repeat (2) begin
      req_data0 = 12'($urandom_range(0, 4095));
      cyc();
    end
    #1;
    total++;
    if (done_cnt0 !== 8'h00) begin
      bad++;
      $display("FAIL wrap_post: got %0d want 0", done_cnt0);
    end
    req_valid = 2'b00;
    repeat (3) cyc();
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", q0.size() + q1.size());
    end
    resp_ready = 2'b00;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req_valid  = 2'b11;
    req_data0  = 12'd0;
    req_data1  = 12'd0;
    resp_ready = 2'b00;
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_corners();
    test_reset_midflight();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
